// File: rtl/fft_bitrev_reorder_if.sv
// Stream bundle between the last FFT butterfly stage, the reorder buffer and its consumer.
// Carries the bit-reversed input stream (iEN/iDATA) and the natural-order output stream (oEN/oDATA/oIDX/oSOF).
// slave: the reorder buffer side; master: the driving/observing side.
interface fft_bitrev_reorder_if #(
  parameter int WL   = 32,
  parameter int LOGN = 4
);
  logic            iEN;
  logic [WL-1:0]   iDATA;
  logic            oEN;
  logic [WL-1:0]   oDATA;
  logic [LOGN-1:0] oIDX;
  logic            oSOF;

  modport slave (
    input  iEN,
    input  iDATA,
    output oEN,
    output oDATA,
    output oIDX,
    output oSOF
  );

  modport master (
    output iEN,
    output iDATA,
    input  oEN,
    input  oDATA,
    input  oIDX,
    input  oSOF
  );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Purpose: ping-pong reorder of a bit-reversed FFT output frame into natural bin order.
// Latency: last input word at edge E -> X[0] valid after E+1, X[N-1] after E+N.
// Backpressure: none; iEN always accepted, read-out never stalls (N oEN cycles per frame).
// Ports: iCLK clock; iRST sync active-high reset; bus (slave) carries iEN/iDATA in,
//        oEN/oDATA/oIDX/oSOF out (all outputs registered).
module fft_bitrev_reorder #(
  parameter int N    = 16,
  parameter int LOGN = 4,
  parameter int WL   = 32
) (
  input  logic                iCLK,
  input  logic                iRST,
  fft_bitrev_reorder_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] READ = 1'b1;

  // Bank select is the address MSB: entries [0..N-1] bank 0, [N..2N-1] bank 1.
  logic [WL-1:0]   mem [0:2*N-1];

  logic [LOGN-1:0] wrCnt;
  logic            wrBank;
  logic [LOGN-1:0] rdCnt;
  logic            rdBank;
  logic [0:0]      rdState;
  logic            frameDone;
  logic            lastRd;

  function automatic logic [LOGN-1:0] bitRev(input logic [LOGN-1:0] v);
    logic [LOGN-1:0] r;
    r = '0;
    for (int b = 0; b < LOGN; b++) r[b] = v[LOGN-1-b];
    return r;
  endfunction

  assign frameDone = bus.iEN && (wrCnt == LOGN'(N-1));
  assign lastRd    = (rdCnt == LOGN'(N-1));

  // Storage is not reset; a reset edge must not write.
  always_ff @(posedge iCLK) begin
    if (!iRST && bus.iEN) begin
      mem[{wrBank, bitRev(wrCnt)}] <= bus.iDATA;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      wrCnt     <= '0;
      wrBank    <= 1'b0;
      rdCnt     <= '0;
      rdBank    <= 1'b0;
      rdState   <= IDLE;
      bus.oEN   <= 1'b0;
      bus.oSOF  <= 1'b0;
      bus.oDATA <= '0;
      bus.oIDX  <= '0;
    end else begin
      if (bus.iEN) begin
        wrCnt <= wrCnt + LOGN'(1);
      end

      // A completing frame hands its bank to the reader. In steady back-to-back
      // streaming this lands exactly on the edge issuing the previous frame's
      // last word, so the reload gives gap-free output.
      if (frameDone) begin
        wrBank  <= ~wrBank;
        rdBank  <= wrBank;
        rdCnt   <= '0;
        rdState <= READ;
      end else if (rdState == READ) begin
        rdCnt <= rdCnt + LOGN'(1);
        if (lastRd) begin
          rdState <= IDLE;
        end
      end

      // Issue uses the pre-edge read pointer; a write at the previous edge is visible here.
      if (rdState == READ) begin
        bus.oDATA <= mem[{rdBank, rdCnt}];
        bus.oIDX  <= rdCnt;
        bus.oEN   <= 1'b1;
        bus.oSOF  <= (rdCnt == '0);
      end else begin
        bus.oEN  <= 1'b0;
        bus.oSOF <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fft_bitrev_reorder.md
# fft_bitrev_reorder

Output reorder buffer placed after the last radix-2 butterfly stage of the 16-point pipelined FFT. The butterfly chain emits each frame in bit-reversed bin order, and this block writes that stream into a ping-pong buffer and reads it back in natural order (X[0], X[1] … X[N-1]). Read-out runs continuously while the next frame is written. The block is the reading end of the FFT output stream: it consumes the same {RE,IM} 32-bit words, qualified by iEN, that the butterfly stages produce.

## Interface
- N, 16: points per frame; power of two.
- LOGN, 4: log2(N); width of index counters.
- WL, 32: word width, {RE[WL-1:WL/2], IM[WL/2-1:0]}, passed through untouched.

- iCLK  in  1  clock, all logic on rising edge.
- iRST  in  1  reset, synchronous, active-high.
- iEN  in  1  input word valid; gaps allowed between and within frames.
- iDATA  in  WL  FFT output word, bit-reversed order within frame.
- oEN  out  1  output word valid (registered).
- oDATA  out  WL  reordered word (registered).
- oIDX  out  LOGN  natural bin index of oDATA (registered).
- oSOF  out  1  high with oEN when oIDX==0 (registered).

## Operation
- Storage: two banks of N×WL words (bank 0, bank 1). Memory contents are not reset.
- Write side:
  - wr_cnt (LOGN bits) counts accepted words. wr_bank selects the target bank.
  - On iEN=1: mem[wr_bank][bitrev(wr_cnt)] <= iDATA; wr_cnt <= wr_cnt+1 (wraps at N).
  - bitrev reverses all LOGN bits. For N=16: 1→8, 2→4, 3→12, 5→10, 15→15.
- Frame completion (iEN=1 and wr_cnt==N-1) does all of the following at that edge:
  - wr_bank toggles.
  - rd_bank <= old wr_bank.
  - rd_cnt <= 0.
  - rd_active <= 1.
- Read side, while rd_active=1, each cycle:
  - oDATA <= mem[rd_bank][rd_cnt]; oIDX <= rd_cnt; oEN <= 1; oSOF <= (rd_cnt==0).
  - rd_cnt increments.
  - After rd_cnt==N-1 is issued, rd_active clears, unless a new frame completes on that same edge (see boundary conditions).
- Read-out never stalls. It always produces N consecutive oEN cycles per frame.
- When not reading: oEN=0, oSOF=0, and oDATA/oIDX hold their last value.
- FSM states:
  - IDLE (rd_active=0) → READ on frame completion.
  - READ → READ on frame completion at rd_cnt==N-1.
  - READ → IDLE at rd_cnt==N-1 with no completion.
- Boundary conditions:
  - Back-to-back frames (iEN continuously 1): the completion of frame k+1 coincides with the issue of the last word of frame k. rd_cnt reloads to 0 and rd_bank switches, giving seamless output with no oEN gap.
  - Overrun is structurally impossible. A frame takes ≥N write cycles and read-out takes exactly N cycles, so the read bank is never overwritten before it is fully issued.
  - Wrap-around: wr_cnt and rd_cnt wrap modulo N. No frame counter is kept.
  - Reset mid-frame: the partial frame is discarded, and the next accepted word is treated as index 0 of a new frame.
  - Reset mid-read-out: read-out stops immediately; oEN=0 on the cycle after the reset edge.
- Reset (iRST=1 at an edge) sets:
  - wr_cnt=0, rd_cnt=0, wr_bank=0, rd_bank=0, rd_active=0.
  - oEN=0, oSOF=0, oDATA=0, oIDX=0.
  - Reset has priority over iEN; no write occurs on a reset edge.

## Timing
- Latency: the last word of a frame is captured at edge E. oEN=1 with oDATA=X[0] is visible after edge E+1. X[N-1] is visible after edge E+N.
- The memory read is combinational from the bank array into the output register. A write at edge E is visible to a read at edge E+1.
- Throughput: one word per clock in each direction, sustained indefinitely.
- No input backpressure. iEN is always accepted.

## Test plan
- Single frame, iEN high 16 cycles, stream word j = {16'(bitrev(j)), 16'(~bitrev(j))} -> starting 1 cycle after the last input, 16 consecutive oEN cycles with oIDX = 0..15 and RE = 0..15 ascending; oSOF only on the first.
- Three back-to-back frames with distinct tags (RE[15:12] = frame number) -> 48 uninterrupted oEN cycles, frame tags 0,1,2 in order, each ascending 0..15.
- Frame with a random iEN duty of about 40% -> identical ordered output; read-out is contiguous 16 cycles starting one cycle after the 16th accepted word.
- iRST asserted after 7 accepted words, then a full 16-word frame -> no output from the partial frame; the output matches the full frame only, with wr_bank restarting at 0.
- iRST asserted at output oIDX==5 -> oEN=0, oDATA=0, oIDX=0 from the next cycle; the next complete input frame is read out correctly from oIDX 0.
- Reset values: hold iRST 3 cycles with iEN=1 and random iDATA -> oEN=0, oSOF=0, oDATA=0, oIDX=0 throughout, and no read-out follows reset release without 16 new words.
